// File: rtl/qcl_domino_pkg.sv
// Shared definitions for the domino-stretched control line (transmit and receive sides).
// Holds the line state encoding and the counter width helper.
package qcl_domino_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STUCK  = 2'd2
  } qcl_state_e;

  // Counter must hold 0..max_els plus headroom so the saturation value is representable.
  function automatic int qcl_cnt_w(input int max_els);
    return $clog2(max_els + 2);
  endfunction

endpackage

// File: rtl/qcl_sat_counter.sv
// Saturating up-counter for the pulse-width measurement.
// Clear has priority; clear together with incr loads 1 so a new pulse is counted immediately.
module qcl_sat_counter
  import qcl_domino_pkg::*;
#(
  parameter int width_p = 4,
  parameter int max_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               incr_i,
  output logic [width_p-1:0] cnt_o,
  output logic               sat_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  logic [width_p-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_o;
    if (clear_i) begin
      cnt_next = incr_i ? width_p'(1) : '0;
    end else if (incr_i && (cnt_o < max_lp)) begin
      cnt_next = cnt_o + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_o <= '0;
    end else begin
      cnt_o <= cnt_next;
    end
  end

  assign sat_o = (cnt_o == max_lp);

endmodule

// File: rtl/qcl_domino_rx.sv
// Receive side of a domino-stretched level: measures active width, filters glitches and
// stuck levels, and emits single-cycle event strobes plus the measured width.
module qcl_domino_rx
  import qcl_domino_pkg::*;
#(
  parameter int   min_els_p = 4,
  parameter int   max_els_p = 64,
  parameter logic val_p     = 1'b1,
  localparam int  cnt_w_lp  = qcl_cnt_w(max_els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                i,
  output logic                first_o,
  output logic                v_o,
  output logic                err_short_o,
  output logic                err_long_o,
  output logic [cnt_w_lp-1:0] len_o
);

  localparam logic [cnt_w_lp-1:0] min_lp      = cnt_w_lp'(min_els_p);
  localparam logic [cnt_w_lp-1:0] first_at_lp = cnt_w_lp'(min_els_p - 1);

  (* shreg_extract = "no" *) logic i_r;

  qcl_state_e          state, state_next;
  logic                act;
  logic                cnt_clear, cnt_incr, cnt_sat;
  logic [cnt_w_lp-1:0] cnt;
  logic                first_next, v_next, short_next, long_next;
  logic [cnt_w_lp-1:0] len_next;

  // Input stage: reset to the inactive level so an already-active line starts a fresh count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      i_r <= ~val_p;
    end else begin
      i_r <= i;
    end
  end

  assign act = (i_r == val_p);

  // IDLE loads 1 on the first active sample; STUCK holds the saturated count.
  assign cnt_clear = (state == IDLE) || !act;
  assign cnt_incr  = act && ((state == IDLE) || ((state == ACTIVE) && !cnt_sat));

  qcl_sat_counter #(
    .width_p (cnt_w_lp),
    .max_p   (max_els_p)
  ) u_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (cnt_clear),
    .incr_i    (cnt_incr),
    .cnt_o     (cnt),
    .sat_o     (cnt_sat)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (act) state_next = ACTIVE;
      ACTIVE:  if (!act) state_next = IDLE;
               else if (cnt_sat) state_next = STUCK;
      STUCK:   if (!act) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    first_next = 1'b0;
    v_next     = 1'b0;
    short_next = 1'b0;
    long_next  = 1'b0;
    len_next   = len_o;
    if (state == ACTIVE) begin
      if (act) begin
        if (!cnt_sat) begin
          first_next = (cnt == first_at_lp);
        end else begin
          long_next = 1'b1;
        end
      end else begin
        len_next = cnt;
        if (cnt >= min_lp) begin
          v_next = 1'b1;
        end else begin
          short_next = 1'b1;
        end
      end
    end
  end

  // Output stage: every strobe and len_o are registered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      first_o     <= 1'b0;
      v_o         <= 1'b0;
      err_short_o <= 1'b0;
      err_long_o  <= 1'b0;
      len_o       <= '0;
    end else begin
      first_o     <= first_next;
      v_o         <= v_next;
      err_short_o <= short_next;
      err_long_o  <= long_next;
      len_o       <= len_next;
    end
  end

  a_min_ok: assert property (@(posedge clk_i) min_els_p >= 2);
  a_max_ok: assert property (@(posedge clk_i) max_els_p >= min_els_p);
  a_i_known: assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown(i));
  a_one_end: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                              $onehot0({v_o, err_short_o, err_long_o}));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                cnt <= cnt_w_lp'(max_els_p));

endmodule
